fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock; the block has one clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request to instruction memory; memory always accepts in the same cycle.
REQ-005 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 imem_valid  input  1  read-data-valid pulse; arrives 1 or more cycles after the request.
REQ-007 imem_rdata  input  32  instruction word, valid with imem_valid.
REQ-008 stall  input  1  downstream (decode/SIGN_EXT) cannot accept; holds the id_* outputs.
REQ-009 redirect  input  1  branch/jump taken; flushes the stage.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 id_valid  output  1  id_instr/id_pc hold a valid instruction.
REQ-012 id_instr  output  32  registered instruction word; feeds the instruct input of SIGN_EXT and the decoder.
REQ-013 id_pc  output  32  address of id_instr.

Function
REQ-014 FSM states: IDLE (no request outstanding), WAIT (one request outstanding), DROP (one outstanding response is to be discarded); at most one request is outstanding, except for a back-to-back reissue in WAIT (REQ-018).
REQ-015 Slot open = !id_valid || !stall; the output register loads only when the slot is open.
REQ-016 Slot-open load priority: skid entry first, then a live imem response, otherwise id_valid<=0.
REQ-017 Issue in IDLE: imem_req=1 when !skid_valid && !redirect; imem_addr=pc; req_pc<=pc; pc<=pc+4; next state WAIT.
REQ-018 Back-to-back issue in WAIT: when imem_valid && !redirect && slot open && !skid_valid, assert imem_req with the next pc; state stays WAIT.
REQ-019 In WAIT, a response with imem_valid && !redirect and the slot not open is written to the one-entry skid buffer (skid_instr, skid_pc=req_pc, skid_valid<=1).
REQ-020 In WAIT, a response with no reissue moves the FSM to IDLE.
REQ-021 Redirect has priority over stall and over a response: id_valid<=0, skid_valid<=0, id_instr<=32'h0000_0013, pc<={redirect_pc[31:2],2'b00}; no request is issued that cycle.
REQ-022 Redirect transitions: WAIT without imem_valid -> DROP; WAIT with imem_valid -> IDLE (response discarded); IDLE -> IDLE; DROP -> DROP, or IDLE if imem_valid.
REQ-023 In DROP, imem_valid discards the data and moves the FSM to IDLE; no issue occurs in DROP.
REQ-024 imem_valid in IDLE is ignored.
REQ-025 pc increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; imem_addr[1:0] is always 2'b00.
REQ-026 Latency: request at cycle N and response at N+1 give id_valid=1 after the edge ending cycle N+1; with a 1-cycle memory and no stall, throughput is one instruction per cycle.
REQ-027 While stall=1 && id_valid=1, id_instr and id_pc remain unchanged.

Reset
REQ-028 rst_n=0 asynchronously forces: state=IDLE, pc=RESET_PC, id_valid=0, id_instr=32'h0000_0013, id_pc=0, skid_valid=0.
REQ-029 A response to a request issued before a mid-operation reset is not tracked; the memory is reset by the same rst_n.
REQ-030 The first imem_req asserts in the first cycle after rst_n deasserts.

Verification
REQ-031 Reset release, 1-cycle memory returning 32'h00A00093 then 32'h00100113, no stall -> id_pc 0 then 4, id_instr matches, id_valid held at 1.
REQ-032 stall=1 for 3 cycles while a response arrives -> id_instr unchanged, skid_valid=1, imem_req=0; after release the skid word appears next and no instruction is lost or duplicated.
REQ-033 redirect=1 with redirect_pc=32'h0000_0103 while in WAIT -> state DROP, late response discarded, next imem_addr=32'h0000_0100, id_valid=0 until its data arrives.
REQ-034 redirect coincident with imem_valid and stall -> response dropped, skid cleared, id_instr=32'h0000_0013, state IDLE.
REQ-035 RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-036 rst_n pulsed low mid-WAIT -> outputs reach reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with one-entry skid buffer, redirect flush and
//            a registered decode-side output (id_*).
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_id_valid;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        w_slot_open;
  logic        w_resp;
  logic        w_issue;

  assign w_slot_open = !r_id_valid || !stall;
  // A response is live only while a request is tracked and no flush is underway.
  assign w_resp      = (r_state == S_WAIT) && imem_valid && !redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect && !r_skid_valid) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_nxt = imem_valid ? S_IDLE : S_DROP;
        end else if (imem_valid) begin
          if (w_slot_open && !r_skid_valid) begin
            w_issue = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (imem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign imem_req  = w_issue;
  assign imem_addr = {r_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_req_pc <= 32'h0000_0000;
    end else if (redirect) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_issue) begin
      r_req_pc <= imem_addr;
      r_pc     <= imem_addr + 32'd4;
    end
  end

  // Skid entry can only exist with no request in flight, so it never races
  // with a live response when the slot opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= c_NOP;
      r_id_pc      <= 32'h0000_0000;
      r_skid_valid <= 1'b0;
      r_skid_instr <= c_NOP;
      r_skid_pc    <= 32'h0000_0000;
    end else if (redirect) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= c_NOP;
      r_skid_valid <= 1'b0;
    end else if (w_slot_open) begin
      if (r_skid_valid) begin
        r_id_valid   <= 1'b1;
        r_id_instr   <= r_skid_instr;
        r_id_pc      <= r_skid_pc;
        r_skid_valid <= 1'b0;
      end else if (w_resp) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata;
        r_id_pc    <= r_req_pc;
      end else begin
        r_id_valid <= 1'b0;
      end
    end else if (w_resp) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_req_pc;
    end
  end

  assign id_valid = r_id_valid;
  assign id_instr = r_id_instr;
  assign id_pc    = r_id_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage: directed vector table,
//            directed corner sequences, and a scoreboarded random phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid, id_valid2;
  logic [31:0] id_instr, id_instr2;
  logic [31:0] id_pc, id_pc2;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_valid(id_valid2),
    .id_instr(id_instr2), .id_pc(id_pc2)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { bit stall; bit req; logic [31:0] addr; bit idv; logic [31:0] idpc; } vec_t;
  typedef struct { int lat; int stall_pct; int redir_pct; int ncyc; } scen_t;

  req_t mem_q[$];
  exp_t sb[$];
  int   cyc = 0;
  int   lat = 1;
  int   n_pass = 0;
  int   n_total = 0;
  int   accepted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return {a[31:2] ^ 30'h1555_0155, 2'b11};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory drives this cycle's response, then outputs are allowed to settle.
  task automatic pre_cycle();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
    end
    #1;
  endtask

  // Record requests, consume delivered instructions, advance one clock.
  task automatic post_cycle();
    exp_t e;
    if (imem_req) begin
      chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
      mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      sb.push_back('{pc: imem_addr, instr: mem_word(imem_addr)});
    end
    if (redirect) begin
      chk("req_on_redirect", 32'(imem_req), 32'h0);
      sb.delete();
    end else if (id_valid && !stall) begin
      if (sb.size() == 0) begin
        chk("unexpected_delivery_pc", id_pc, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
        accepted++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int new_lat);
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_valid = 1'b0;
    mem_q.delete();
    sb.delete();
    lat = new_lat;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t  tbl[10];
  scen_t scn[4];

  initial begin
    tbl[0] = '{0, 1, 32'h00, 0, 32'h0};
    tbl[1] = '{0, 1, 32'h04, 0, 32'h0};
    tbl[2] = '{0, 1, 32'h08, 1, 32'h0};
    tbl[3] = '{1, 0, 32'h00, 1, 32'h4};
    tbl[4] = '{1, 0, 32'h00, 1, 32'h4};
    tbl[5] = '{1, 0, 32'h00, 1, 32'h4};
    tbl[6] = '{0, 0, 32'h00, 1, 32'h4};
    tbl[7] = '{0, 1, 32'h0C, 1, 32'h8};
    tbl[8] = '{0, 1, 32'h10, 0, 32'h0};
    tbl[9] = '{0, 1, 32'h14, 1, 32'hC};
    scn[0] = '{1, 0, 0, 150};
    scn[1] = '{1, 30, 5, 300};
    scn[2] = '{2, 40, 5, 300};
    scn[3] = '{3, 25, 8, 300};

    // Reset state, checked while rst_n is low.
    @(negedge clk);
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'h0);

    // Directed table: 1-cycle memory, 3-cycle stall while a response lands.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      stall = tbl[i].stall;
      pre_cycle();
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_idv", i), 32'(id_valid), 32'(tbl[i].idv));
      if (tbl[i].idv) chk($sformatf("tbl%0d_idpc", i), id_pc, tbl[i].idpc);
      if (i == 0) chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_second_addr", imem_addr2, 32'h0000_0000);
      post_cycle();
    end
    stall = 1'b0;

    // Redirect while waiting on a slow memory: late response must be dropped.
    do_reset(3);
    pre_cycle(); chk("drop_issue0", imem_addr, 32'h0); post_cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    pre_cycle(); post_cycle();
    redirect = 1'b0;
    pre_cycle(); chk("drop_noreq_a", 32'(imem_req), 32'h0); post_cycle();
    pre_cycle();
    chk("drop_late_resp", 32'(imem_valid), 32'h1);
    chk("drop_noreq_b", 32'(imem_req), 32'h0);
    post_cycle();
    pre_cycle();
    chk("drop_idv_after", 32'(id_valid), 32'h0);
    chk("redir_req", 32'(imem_req), 32'h1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    post_cycle();
    for (int i = 0; i < 3; i++) begin
      pre_cycle(); chk("redir_idv_wait", 32'(id_valid), 32'h0); post_cycle();
    end
    pre_cycle();
    chk("redir_idv", 32'(id_valid), 32'h1);
    chk("redir_idpc", id_pc, 32'h0000_0100);
    post_cycle();

    // Redirect coincident with a response and stall.
    do_reset(1);
    pre_cycle(); post_cycle();
    pre_cycle(); post_cycle();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    pre_cycle();
    chk("rsv_pre_idv", 32'(id_valid), 32'h1);
    chk("rsv_resp_present", 32'(imem_valid), 32'h1);
    post_cycle();
    stall = 1'b0; redirect = 1'b0;
    pre_cycle();
    chk("rsv_idv", 32'(id_valid), 32'h0);
    chk("rsv_nop", id_instr, 32'h0000_0013);
    chk("rsv_issue_addr", imem_addr, 32'h0000_0040);
    post_cycle();
    pre_cycle(); chk("rsv_skid_cleared", 32'(id_valid), 32'h0); post_cycle();
    pre_cycle();
    chk("rsv_idv_new", 32'(id_valid), 32'h1);
    chk("rsv_idpc_new", id_pc, 32'h0000_0040);
    post_cycle();

    // Asynchronous reset mid-WAIT, then first request right after release.
    do_reset(1);
    repeat (4) begin pre_cycle(); post_cycle(); end
    pre_cycle();
    chk("arst_pre_idv", 32'(id_valid), 32'h1);
    #2 rst_n = 1'b0;
    mem_q.delete();
    sb.delete();
    #1;
    chk("arst_idv", 32'(id_valid), 32'h0);
    chk("arst_instr", id_instr, 32'h0000_0013);
    chk("arst_idpc", id_pc, 32'h0);
    chk("arst_pc", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pre_cycle();
    chk("arst_first_req", 32'(imem_req), 32'h1);
    chk("arst_first_addr", imem_addr, 32'h0);
    post_cycle();
    repeat (5) begin pre_cycle(); post_cycle(); end

    // Scoreboarded random phases across latencies, stalls and redirects.
    for (int s = 0; s < 4; s++) begin
      do_reset(scn[s].lat);
      accepted = 0;
      for (int c = 0; c < scn[s].ncyc; c++) begin
        stall = ($urandom_range(99) < scn[s].stall_pct);
        redirect = ($urandom_range(99) < scn[s].redir_pct);
        redirect_pc = $urandom;
        pre_cycle();
        post_cycle();
      end
      redirect = 1'b0;
      stall = 1'b0;
      n_total++;
      if (accepted >= scn[s].ncyc / 10) n_pass++;
      else $display("FAIL progress_scn%0d: got %0d deliveries expected at least %0d",
                    s, accepted, scn[s].ncyc / 10);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
